// File: rtl/coil_phase_decoder.sv
// Stepper coil drive decoder: synchronizes and debounces the 4-wire coil pattern,
// then tracks half-step phase, signed position, step direction and step period.
module coil_phase_decoder #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic [3:0]         coil_in,
  output logic               step_pulse,
  output logic               step_dir,
  output logic signed [31:0] position,
  output logic [2:0]         phase,
  output logic               phase_valid,
  output logic [31:0]        period,
  output logic               err_illegal,
  output logic               err_skip
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  typedef enum logic {IDLE, TRACK} state_t;

  // Returns {legal, phase_index}; idle and illegal patterns both report legal = 0.
  function automatic logic [3:0] decode(input logic [3:0] p);
    case (p)
      4'b1000: decode = 4'b1_000;
      4'b1010: decode = 4'b1_001;
      4'b0010: decode = 4'b1_010;
      4'b0110: decode = 4'b1_011;
      4'b0100: decode = 4'b1_100;
      4'b0101: decode = 4'b1_101;
      4'b0001: decode = 4'b1_110;
      4'b1001: decode = 4'b1_111;
      default: decode = 4'b0_000;
    endcase
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [3:0]         sync_q [SYNC_STAGES];
  logic [3:0]         sync_d [SYNC_STAGES];
  logic [3:0]         cand_q, cand_d, last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  state_t             state_q, state_d;
  logic [2:0]         phase_q, phase_d;
  logic signed [31:0] pos_q, pos_d;
  logic               dir_q, dir_d, pulse_q, pulse_d;
  logic [31:0]        period_q, period_d, ivl_q, ivl_d;
  logic               first_q, first_d;
  logic               err_ill_q, err_ill_d, err_skip_q, err_skip_d;

  logic               accept, step;
  logic [3:0]         dec;
  logic [2:0]         delta;

  always_comb begin
    sync_d[0] = coil_in;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  // Stability filter: the count restarts whenever the synchronized value moves.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    last_d = last_q;
    if (sync_q[SYNC_STAGES-1] != cand_q) begin
      cand_d = sync_q[SYNC_STAGES-1];
      cnt_d  = CNT_W'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    accept = (cnt_q == CNT_MAX) && (cand_q != last_q);
    if (accept) last_d = cand_q;
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    pos_d      = pos_q;
    dir_d      = dir_q;
    pulse_d    = 1'b0;
    period_d   = period_q;
    ivl_d      = sat_inc(ivl_q);
    first_d    = first_q;
    err_ill_d  = err_ill_q;
    err_skip_d = err_skip_q;
    step       = 1'b0;
    dec        = decode(cand_q);
    delta      = dec[2:0] - phase_q;
    if (accept) begin
      if (dec[3]) begin
        if (state_q == IDLE) begin
          phase_d = dec[2:0];
          state_d = TRACK;
          first_d = 1'b1;
        end else if (delta == 3'd1 || delta == 3'd7) begin
          step    = 1'b1;
          phase_d = dec[2:0];
          dir_d   = (delta == 3'd7);
          pos_d   = (delta == 3'd1) ? pos_q + 32'sd1 : pos_q - 32'sd1;
          pulse_d = 1'b1;
        end else if (delta != 3'd0) begin
          err_skip_d = 1'b1;
          phase_d    = dec[2:0];
        end
      end else if (cand_q == 4'b0000) begin
        state_d = IDLE;
      end else begin
        err_ill_d = 1'b1;
      end
    end
    // The interval count restarts at 1 so the next step sees the full cycle distance.
    if (step) begin
      period_d = first_q ? 32'd0 : ivl_q;
      ivl_d    = 32'd1;
      first_d  = 1'b0;
    end
    if (clr) begin
      pos_d      = '0;
      period_d   = '0;
      ivl_d      = '0;
      err_ill_d  = 1'b0;
      err_skip_d = 1'b0;
      first_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      cand_q     <= '0;
      cnt_q      <= '0;
      last_q     <= '0;
      state_q    <= IDLE;
      phase_q    <= '0;
      pos_q      <= '0;
      dir_q      <= 1'b0;
      pulse_q    <= 1'b0;
      period_q   <= '0;
      ivl_q      <= '0;
      first_q    <= 1'b1;
      err_ill_q  <= 1'b0;
      err_skip_q <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      state_q    <= state_d;
      phase_q    <= phase_d;
      pos_q      <= pos_d;
      dir_q      <= dir_d;
      pulse_q    <= pulse_d;
      period_q   <= period_d;
      ivl_q      <= ivl_d;
      first_q    <= first_d;
      err_ill_q  <= err_ill_d;
      err_skip_q <= err_skip_d;
    end
  end

  assign step_pulse  = pulse_q;
  assign step_dir    = dir_q;
  assign position    = pos_q;
  assign phase       = phase_q;
  assign phase_valid = (state_q == TRACK);
  assign period      = period_q;
  assign err_illegal = err_ill_q;
  assign err_skip    = err_skip_q;

endmodule

// File: tb/tb_coil_phase_decoder.sv
// Scoreboard bench for coil_phase_decoder: drivers queue expected steps, a monitor
// pops and compares them whenever step_pulse is seen.
module tb_coil_phase_decoder;

  logic               clk = 1'b0;
  logic               rst, clr;
  logic [3:0]         coil_in;
  logic               step_pulse, step_dir, phase_valid, err_illegal, err_skip;
  logic signed [31:0] position;
  logic [2:0]         phase;
  logic [31:0]        period;

  coil_phase_decoder #(.SYNC_STAGES(2), .STABLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .clr(clr), .coil_in(coil_in),
    .step_pulse(step_pulse), .step_dir(step_dir), .position(position),
    .phase(phase), .phase_valid(phase_valid), .period(period),
    .err_illegal(err_illegal), .err_skip(err_skip)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dir;
    logic [31:0] pos;
    logic [31:0] per;
    logic [2:0]  ph;
    int          at_edge;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   npulse = 0;
  int   t0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input logic dir, input logic [31:0] pos, input logic [31:0] per,
                      input logic [2:0] ph, input int at_edge);
    exp_t e;
    e.dir = dir; e.pos = pos; e.per = per; e.ph = ph; e.at_edge = at_edge;
    sb.push_back(e);
  endtask

  // Called at a falling edge; holds pat for n cycles and leaves us at a falling edge.
  task automatic drive(input logic [3:0] pat, input int n);
    coil_in = pat;
    t0 = cyc;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_step(input logic [3:0] pat, input logic dir, input logic [31:0] pos,
                            input logic [31:0] per, input logic [2:0] ph);
    push(dir, pos, per, ph, cyc + 7);
    drive(pat, 20);
  endtask

  always @(negedge clk) begin
    if (!rst && step_pulse) begin
      exp_t e;
      npulse++;
      if (sb.size() == 0) begin
        check("unexpected_step", 32'(step_pulse), 32'd0);
      end else begin
        e = sb.pop_front();
        check("step_edge", cyc, e.at_edge);
        check("step_dir", 32'(step_dir), 32'(e.dir));
        check("step_position", position, e.pos);
        check("step_period", period, e.per);
        check("step_phase", 32'(phase), 32'(e.ph));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  int np;

  initial begin
    rst = 1'b1; clr = 1'b0; coil_in = 4'b1010;
    repeat (4) @(negedge clk);
    check("rst_step_pulse", 32'(step_pulse), 32'd0);
    check("rst_step_dir", 32'(step_dir), 32'd0);
    check("rst_position", position, 32'd0);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_phase_valid", 32'(phase_valid), 32'd0);
    check("rst_period", period, 32'd0);
    check("rst_err_illegal", 32'(err_illegal), 32'd0);
    check("rst_err_skip", 32'(err_skip), 32'd0);
    rst = 1'b0; coil_in = 4'b0000;
    repeat (10) @(negedge clk);

    // Load then two CW steps
    np = npulse;
    drive(4'b1000, 20);
    check("load_no_step", npulse - np, 0);
    check("load_phase_valid", 32'(phase_valid), 32'd1);
    drive_step(4'b1010, 1'b0, 32'd1, 32'd0,  3'd1);
    drive_step(4'b0010, 1'b0, 32'd2, 32'd20, 3'd2);
    check("cw_position", position, 32'd2);
    check("cw_step_dir", 32'(step_dir), 32'd0);
    check("cw_period", period, 32'd20);

    // CCW back to phase 0 then two more CCW steps
    drive_step(4'b1010, 1'b1, 32'd1,          32'd20, 3'd1);
    drive_step(4'b1000, 1'b1, 32'd0,          32'd20, 3'd0);
    drive_step(4'b1001, 1'b1, 32'hFFFF_FFFF,  32'd20, 3'd7);
    drive_step(4'b0001, 1'b1, 32'hFFFF_FFFE,  32'd20, 3'd6);
    check("ccw_position", position, 32'hFFFF_FFFE);
    check("ccw_step_dir_held", 32'(step_dir), 32'd1);
    drive_step(4'b1001, 1'b0, 32'hFFFF_FFFF,  32'd20, 3'd7);
    drive_step(4'b1000, 1'b0, 32'd0,          32'd20, 3'd0);

    // Wrap-around at the signed limit
    force dut.pos_q = 32'sh8000_0000;
    @(negedge clk);
    release dut.pos_q;
    drive_step(4'b1001, 1'b1, 32'h7FFF_FFFF, 32'd21, 3'd7);
    drive_step(4'b1000, 1'b0, 32'h8000_0000, 32'd20, 3'd0);

    // Short glitch inside a held pattern
    drive_step(4'b1010, 1'b0, 32'h8000_0001, 32'd20, 3'd1);
    np = npulse;
    drive(4'b0110, 2);
    drive(4'b1010, 20);
    check("glitch_no_step", npulse - np, 0);
    check("glitch_err_skip", 32'(err_skip), 32'd0);
    check("glitch_err_illegal", 32'(err_illegal), 32'd0);
    check("glitch_phase", 32'(phase), 32'd1);

    // Skip and illegal patterns
    drive_step(4'b1000, 1'b1, 32'h8000_0000, 32'd42, 3'd0);
    np = npulse;
    drive(4'b0100, 20);
    check("skip_err_skip", 32'(err_skip), 32'd1);
    check("skip_phase", 32'(phase), 32'd4);
    check("skip_position", position, 32'h8000_0000);
    check("skip_no_step", npulse - np, 0);
    drive(4'b1111, 20);
    check("illegal_err_illegal", 32'(err_illegal), 32'd1);
    check("illegal_phase", 32'(phase), 32'd4);
    check("illegal_phase_valid", 32'(phase_valid), 32'd1);

    // Standalone clear
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_position", position, 32'd0);
    check("clr_period", period, 32'd0);
    check("clr_err_illegal", 32'(err_illegal), 32'd0);
    check("clr_err_skip", 32'(err_skip), 32'd0);
    check("clr_phase_kept", 32'(phase), 32'd4);
    drive_step(4'b0101, 1'b0, 32'd1, 32'd0,  3'd5);
    drive_step(4'b0001, 1'b0, 32'd2, 32'd20, 3'd6);
    drive_step(4'b1001, 1'b0, 32'd3, 32'd20, 3'd7);
    drive_step(4'b1000, 1'b0, 32'd4, 32'd20, 3'd0);
    drive_step(4'b1010, 1'b0, 32'd5, 32'd20, 3'd1);
    drive(4'b0110, 20);
    check("pre_clr_err_skip", 32'(err_skip), 32'd1);

    // Clear coinciding with a step
    push(1'b0, 32'd0, 32'd0, 3'd4, cyc + 7);
    coil_in = 4'b0100;
    repeat (6) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (13) @(negedge clk);
    check("clrstep_err_skip", 32'(err_skip), 32'd0);
    check("clrstep_position", position, 32'd0);

    // Idle pattern, then re-entry only loads phase
    drive(4'b0000, 20);
    check("idle_phase_valid", 32'(phase_valid), 32'd0);
    check("idle_phase_held", 32'(phase), 32'd4);
    check("idle_position_held", position, 32'd0);
    np = npulse;
    drive(4'b1000, 20);
    check("reentry_no_step", npulse - np, 0);
    check("reentry_phase", 32'(phase), 32'd0);
    check("reentry_phase_valid", 32'(phase_valid), 32'd1);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/coil_phase_decoder.md
COIL_PHASE_DECODER -- requirements
Module: coil_phase_decoder

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of input synchronizer flops, minimum 2.
REQ-002 Parameter STABLE_CYCLES, default 4: consecutive cycles a synchronized pattern must hold before it is accepted, minimum 1.
REQ-003 clk  input  1  single clock; every flop shall be clocked on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 clr  input  1  synchronous clear of position, period and error flags.
REQ-006 coil_in  input  4  coil drive pattern {IN1,IN2,IN3,IN4}; asynchronous to clk.
REQ-007 step_pulse  output  1  one-cycle strobe per decoded half-step.
REQ-008 step_dir  output  1  direction of the last step: 0 = CW (phase +1), 1 = CCW (phase -1).
REQ-009 position  output  32  signed half-step count.
REQ-010 phase  output  3  current decoded phase index.
REQ-011 phase_valid  output  1  high while in the TRACK state.
REQ-012 period  output  32  clock cycles between the last two step_pulse strobes.
REQ-013 err_illegal  output  1  sticky flag: an illegal pattern was accepted.
REQ-014 err_skip  output  1  sticky flag: a phase jump of 2 to 6 was accepted.

Function
REQ-015 The decode table shall be: 1000=0, 1010=1, 0010=2, 0110=3, 0100=4, 0101=5, 0001=6, 1001=7.
- 0000 is the idle pattern.
- All other 7 patterns are illegal.
REQ-016 coil_in shall pass through a SYNC_STAGES-deep synchronizer and then a stability filter.
- The filter counter restarts on any change of the synchronized value.
- A pattern is accepted once it has held STABLE_CYCLES cycles and differs from the last accepted pattern.
- Each acceptance produces exactly one internal accept strobe.
REQ-017 Latency: step_pulse shall assert on rising edge SYNC_STAGES+STABLE_CYCLES+1, counted from the first edge at which coil_in holds the new pattern.
- With default parameters this is edge 7.
- A glitch shorter than STABLE_CYCLES synchronized cycles shall produce no acceptance.
REQ-018 The state machine shall have two states, IDLE and TRACK.
REQ-019 In IDLE, accepting a legal phase pattern shall:
- load phase;
- enter TRACK;
- assert no step_pulse and leave position unchanged.
REQ-020 In TRACK, on accepting a legal pattern, compute d = (new - phase) mod 8:
- d = 1: position += 1, step_dir = 0, step_pulse = 1.
- d = 7: position -= 1, step_dir = 1, step_pulse = 1.
- d = 2 to 6: set err_skip, load phase = new, no step and no position change.
REQ-021 In TRACK, accepting 0000 shall enter IDLE, clear phase_valid, and hold phase, position and period.
REQ-022 In either state, accepting an illegal pattern shall set err_illegal and leave state, phase and position unchanged.
REQ-023 Position arithmetic shall be 32-bit two's complement with wrap-around: 0x7FFFFFFF + 1 = 0x80000000, and 0x80000000 - 1 = 0x7FFFFFFF.
REQ-024 The interval counter shall:
- increment every cycle and saturate at 0xFFFFFFFF;
- on each step_pulse, load period with the count of cycles since the previous step_pulse, then restart.
REQ-025 The first step after reset, after clr, or after entry to TRACK from IDLE shall report period = 0.
REQ-026 clr shall zero position, period, err_illegal, err_skip and the interval counter, and shall not alter state, phase or the filter.
REQ-027 If clr coincides with a step, clr wins: position = 0 and period = 0, while step_pulse and step_dir still reflect the step.
REQ-028 step_dir shall hold its last value between steps.

Reset
REQ-029 While rst is high, all of the following shall be 0:
- every output;
- the synchronizer flops;
- the filter counter;
- the last accepted pattern (0000);
- the interval counter.
The state shall be IDLE.
REQ-030 Deasserting rst mid-sequence shall resume from IDLE, so the first legal pattern only loads phase.
REQ-031 Asserting rst during a pending acceptance shall discard that acceptance.

Verification
REQ-032 The bench shall apply reset and then drive 1000, 1010, 0010, each held 20 cycles -> one load and two steps: position = 2, step_dir = 0, period = 20, first step_pulse at edge 7 after the 1010 change.
REQ-033 The bench shall drive the CCW sequence 1000, 1001, 0001 from TRACK at phase 0 -> position -= 2 with step_dir = 1, and at phase 0 from position 0x80000000 a 1001 step -> position = 0x7FFFFFFF.
REQ-034 The bench shall insert a 2-cycle 0110 glitch within a held 1010 -> no acceptance, no step_pulse, no error.
REQ-035 The bench shall apply 1000 followed by 0100 (jump of 4) -> err_skip = 1, phase = 4, position unchanged; then 1111 -> err_illegal = 1, phase stays 4.
REQ-036 The bench shall assert clr in the same cycle as a step from position 5 -> position = 0, step_pulse = 1, err flags cleared; then 0000 -> phase_valid = 0, position held.
